cachemem_ext: RTL

Byte-lane simple dual-port cache data array with built-in flush and write-to-read forwarding. One synchronous read port and one byte-masked write port. A clear engine sweeps every line to a fixed value after reset or on request. Configurable output register for timing closure. Used as the data/tag store under the cache controllers; reads are qualified by a valid strobe so controllers never sample stale data during a flush.

---
 rtl/cachemem_pkg.sv | 19 +
 rtl/cache_lane8.sv | 29 ++
 rtl/cachemem_ext.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cachemem_pkg.sv
// Shared types and constants for the cachemem_ext data array: FSM encoding,
// vendor select codes and a read-latency helper.
package cachemem_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } cm_state_e;

  localparam logic [1:0] VENDOR_ALTERA  = 2'b11;
  localparam logic [1:0] VENDOR_ANLOGIC = 2'b10;
  localparam logic [1:0] VENDOR_GOWIN   = 2'b01;
  localparam logic [1:0] GENERIC_ASRAM  = 2'b00;

  function automatic int unsigned read_latency(input int unsigned out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/cache_lane8.sv
// One 8-bit byte lane of the cache data array: synchronous read, single write
// port, no reset so it maps onto block RAM.
module cache_lane8
  import cachemem_pkg::*;
#(
  parameter int unsigned memdepth = 2048,
  parameter int unsigned AddrW    = $clog2(memdepth)
) (
  input  logic             clk_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i
);

  logic [7:0] mem_q [memdepth];
  logic [7:0] rdata_q;

  // Read returns the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cachemem_ext.sv
// Byte-lane simple dual-port cache data array with a clear sweep engine,
// per-lane write-to-read forwarding and an optional output register.
module cachemem_ext
  import cachemem_pkg::*;
#(
  parameter int unsigned datawidth    = 64,
  parameter int unsigned cache_depth  = 2048,
  parameter int unsigned cswidth      = datawidth / 8,
  parameter int unsigned addr_wid     = $clog2(cache_depth),
  parameter int unsigned addr_lsb     = $clog2(cswidth),
  parameter int unsigned out_reg      = 0,
  parameter int unsigned clear_on_rst = 1,
  parameter logic [7:0]  clear_val    = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [addr_wid+addr_lsb-1:0] raddr,
  input  logic                         re,
  input  logic [addr_wid+addr_lsb-1:0] waddr,
  input  logic [datawidth-1:0]         di,
  input  logic                         we,
  input  logic [cswidth-1:0]           bsel,
  input  logic                         clr_req,
  output logic [datawidth-1:0]         dato,
  output logic                         dvalid,
  output logic                         busy
);

  localparam int unsigned Latency = read_latency(out_reg);
  localparam logic [addr_wid-1:0] LastLine = addr_wid'(cache_depth - 1);

  if (cache_depth == 0 || (cache_depth & (cache_depth - 1)) != 0) begin : g_bad_depth
    $error("cache_depth must be a power of 2");
  end

  cm_state_e state_q, state_d;
  logic [addr_wid-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic rvld_q, rvld_d;
  logic match_q, match_d;
  logic [cswidth-1:0] bsel_q, bsel_d;
  logic [datawidth-1:0] di_q, di_d;
  logic [datawidth-1:0] dato_q, dato_d;
  logic dvalid_q, dvalid_d;

  logic [addr_wid-1:0] ridx, widx, arr_waddr;
  logic rd_acc, wr_acc;
  logic [cswidth-1:0] lane_we;
  logic [datawidth-1:0] arr_wdata, arr_rdata, fwd_data;
  logic stg_vld;
  logic [datawidth-1:0] stg_data;
  logic unused_lsb;

  assign ridx       = raddr[addr_wid+addr_lsb-1:addr_lsb];
  assign widx       = waddr[addr_wid+addr_lsb-1:addr_lsb];
  assign unused_lsb = ^{raddr[addr_lsb-1:0], waddr[addr_lsb-1:0]};
  assign rd_acc     = re & ~busy_q;
  assign wr_acc     = we & ~busy_q;
  assign arr_waddr  = busy_q ? cnt_q : widx;

  for (genvar i = 0; i < cswidth; i++) begin : g_lane
    assign lane_we[i]          = busy_q | (wr_acc & bsel[i]);
    assign arr_wdata[8*i +: 8] = busy_q ? clear_val : di[8*i +: 8];

    cache_lane8 #(
      .memdepth (cache_depth)
    ) u_lane (
      .clk_i   (clk),
      .re_i    (rd_acc),
      .raddr_i (ridx),
      .rdata_o (arr_rdata[8*i +: 8]),
      .we_i    (lane_we[i]),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata[8*i +: 8])
    );
  end

  // Lanes written in the same cycle as the read return the new byte.
  always_comb begin
    fwd_data = arr_rdata;
    for (int i = 0; i < int'(cswidth); i++) begin
      if (match_q && bsel_q[i]) fwd_data[8*i +: 8] = di_q[8*i +: 8];
    end
  end

  if (Latency == 2) begin : g_out_reg
    logic pipe_vld_q;
    logic [datawidth-1:0] pipe_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_vld_q  <= 1'b0;
        pipe_data_q <= '0;
      end else begin
        pipe_vld_q  <= rvld_q;
        pipe_data_q <= fwd_data;
      end
    end

    assign stg_vld  = pipe_vld_q;
    assign stg_data = pipe_data_q;
  end else begin : g_no_out_reg
    assign stg_vld  = rvld_q;
    assign stg_data = fwd_data;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        cnt_d = cnt_q + addr_wid'(1);
        if (cnt_q == LastLine) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    rvld_d   = rd_acc;
    match_d  = rd_acc & wr_acc & (ridx == widx);
    bsel_d   = bsel;
    di_d     = di;
    dato_d   = stg_vld ? stg_data : dato_q;
    dvalid_d = stg_vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (clear_on_rst != 0) ? StClear : StIdle;
      busy_q   <= (clear_on_rst != 0);
      cnt_q    <= '0;
      rvld_q   <= 1'b0;
      match_q  <= 1'b0;
      bsel_q   <= '0;
      di_q     <= '0;
      dato_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rvld_q   <= rvld_d;
      match_q  <= match_d;
      bsel_q   <= bsel_d;
      di_q     <= di_d;
      dato_q   <= dato_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dato   = dato_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;

endmodule
